// File: rtl/lif_layer_scheduler_pkg.sv
// Shared types and sizing helpers for the time-multiplexed LIF layer scheduler.
// Holds the FSM encoding, the weight polarity constants and the membrane/threshold width derivations.
package lif_layer_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A set weight bit is an excitatory (+1) synapse, a clear bit an inhibitory (-1) one.
  localparam logic WEIGHT_POS = 1'b1;
  localparam logic WEIGHT_NEG = 1'b0;

  localparam int SHIFT_BITS = 3;

  function automatic int membrane_bits(input int stage);
    return stage + 2;
  endfunction

  function automatic int threshold_bits(input int mbits);
    return mbits - 1;
  endfunction

endpackage

// File: rtl/lif_layer_scheduler_logic.sv
// Single-neuron LIF datapath: binary-weight synaptic sum, shift decay,
// saturating accumulate, threshold compare and reset-by-subtraction.
module lif_logic
  import lif_layer_scheduler_pkg::*;
#(
  parameter int SYNAPSES       = 8,
  parameter int MEMBRANE_BITS  = membrane_bits($clog2(SYNAPSES)),
  parameter int THRESHOLD_BITS = threshold_bits(MEMBRANE_BITS)
) (
  input  logic [SYNAPSES-1:0]              spikes_i,
  input  logic [SYNAPSES-1:0]              weights_i,
  input  logic signed [MEMBRANE_BITS-1:0]  membrane_i,
  input  logic [SHIFT_BITS-1:0]            shift_i,
  input  logic [THRESHOLD_BITS-1:0]        threshold_i,
  output logic signed [MEMBRANE_BITS-1:0]  membrane_o,
  output logic                             spike_o
);

  // One guard bit lets the sum of decayed membrane and psp be tested before clamping.
  localparam int SUM_BITS = MEMBRANE_BITS + 1;
  localparam logic signed [SUM_BITS-1:0] SAT_MAX = SUM_BITS'((2 ** (MEMBRANE_BITS - 1)) - 1);
  localparam logic signed [SUM_BITS-1:0] SAT_MIN = SUM_BITS'(-(2 ** (MEMBRANE_BITS - 1)));

  logic signed [SUM_BITS-1:0]      psp;
  logic signed [SUM_BITS-1:0]      sum;
  logic signed [MEMBRANE_BITS-1:0] decay_amt;
  logic signed [MEMBRANE_BITS-1:0] decayed;
  logic signed [MEMBRANE_BITS-1:0] acc;
  logic signed [MEMBRANE_BITS-1:0] thr_ext;

  // NOTE: combinational blocks use blocking '=' so later lines see earlier results in the same pass.
  always_comb begin
    psp = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (spikes_i[i]) begin
        if (weights_i[i] == WEIGHT_POS) begin
          psp = psp + SUM_BITS'(1);
        end else if (weights_i[i] == WEIGHT_NEG) begin
          psp = psp - SUM_BITS'(1);
        end
      end
    end
  end

  // A zero shift means "no decay"; u - (u >>> 0) would instead wipe the membrane.
  assign decay_amt = membrane_i >>> shift_i;
  assign decayed   = (shift_i == '0) ? membrane_i : membrane_i - decay_amt;
  assign sum       = {decayed[MEMBRANE_BITS-1], decayed} + psp;

  // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    acc = sum[MEMBRANE_BITS-1:0];
    if (sum > SAT_MAX) begin
      acc = SAT_MAX[MEMBRANE_BITS-1:0];
    end else if (sum < SAT_MIN) begin
      acc = SAT_MIN[MEMBRANE_BITS-1:0];
    end
  end

  assign thr_ext    = {{(MEMBRANE_BITS - THRESHOLD_BITS){1'b0}}, threshold_i};
  assign spike_o    = (acc >= thr_ext);
  assign membrane_o = spike_o ? (acc - thr_ext) : acc;

endmodule

// File: rtl/lif_layer_scheduler.sv
// Layer scheduler: stores per-neuron weight rows and membranes and steps every
// neuron through one shared lif_logic datapath, one neuron per cycle per timestep.
module lif_layer_scheduler
  import lif_layer_scheduler_pkg::*;
#(
  parameter int NEURONS        = 4,
  parameter int SYNAPSES       = 8,
  parameter int STAGE          = $clog2(SYNAPSES),
  parameter int MEMBRANE_BITS  = membrane_bits(STAGE),
  parameter int THRESHOLD_BITS = threshold_bits(MEMBRANE_BITS),
  parameter int NIDX_BITS      = $clog2(NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SYNAPSES-1:0]        in_spikes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS-1:0]         out_spikes,
  input  logic                       cfg_we,
  input  logic [NIDX_BITS-1:0]       cfg_addr,
  input  logic [SYNAPSES-1:0]        cfg_data,
  input  logic                       clear_membranes,
  input  logic [SHIFT_BITS-1:0]      shift,
  input  logic [THRESHOLD_BITS-1:0]  threshold,
  output logic                       busy
);

  state_e                      state_q, state_d;
  logic [NIDX_BITS-1:0]        idx_q, idx_d;
  logic [SYNAPSES-1:0]         spikes_q;
  logic [SHIFT_BITS-1:0]       shift_q;
  logic [THRESHOLD_BITS-1:0]   threshold_q;
  logic [NEURONS-1:0]          acc_q;

  logic [SYNAPSES-1:0]             weights_q [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] mem_q     [NEURONS];

  logic                            in_fire;
  logic                            last_neuron;
  logic signed [MEMBRANE_BITS-1:0] dp_membrane;
  logic                            dp_spike;

  assign in_fire     = in_valid && in_ready;
  assign last_neuron = (idx_q == NIDX_BITS'(NEURONS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_neuron) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + NIDX_BITS'(1);
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: clocked state is written with non-blocking '<=' so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spikes_q    <= '0;
      shift_q     <= '0;
      threshold_q <= '0;
      acc_q       <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (in_fire) begin
        spikes_q    <= in_spikes;
        shift_q     <= shift;
        threshold_q <= threshold;
        acc_q       <= '0;
      end else if (state_q == ST_RUN) begin
        acc_q[idx_q] <= dp_spike;
      end
    end
  end

  // NOTE: this storage is deliberately reset: a reset must leave every membrane and weight row at zero,
  // which a memory macro without reset could not guarantee.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NEURONS; n++) begin
        weights_q[n] <= '0;
        mem_q[n]     <= '0;
      end
    end else if (state_q == ST_IDLE) begin
      if (cfg_we) begin
        weights_q[cfg_addr] <= cfg_data;
      end
      // The RUN state reads membranes only from the next cycle on, so a clear in the
      // handshake cycle is seen by the timestep it starts.
      if (clear_membranes) begin
        for (int n = 0; n < NEURONS; n++) begin
          mem_q[n] <= '0;
        end
      end
    end else if (state_q == ST_RUN) begin
      mem_q[idx_q] <= dp_membrane;
    end
  end

  lif_logic #(
    .SYNAPSES       (SYNAPSES),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS)
  ) u_lif_logic (
    .spikes_i    (spikes_q),
    .weights_i   (weights_q[idx_q]),
    .membrane_i  (mem_q[idx_q]),
    .shift_i     (shift_q),
    .threshold_i (threshold_q),
    .membrane_o  (dp_membrane),
    .spike_o     (dp_spike)
  );

  assign out_spikes = acc_q;

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Randomised scoreboard bench for lif_layer_scheduler: a behavioural layer model predicts
// each timestep's spike vector, and an independent monitor compares it at the output handshake.
module tb_lif_layer_scheduler;

  localparam int NEURONS        = 4;
  localparam int SYNAPSES       = 8;
  localparam int MEMBRANE_BITS  = 5;
  localparam int THRESHOLD_BITS = 4;
  localparam int NIDX_BITS      = 2;
  localparam int MEM_MAX        = (2 ** (MEMBRANE_BITS - 1)) - 1;
  localparam int MEM_MIN        = -(2 ** (MEMBRANE_BITS - 1));

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [SYNAPSES-1:0]       in_spikes;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURONS-1:0]        out_spikes;
  logic                      cfg_we;
  logic [NIDX_BITS-1:0]      cfg_addr;
  logic [SYNAPSES-1:0]       cfg_data;
  logic                      clear_membranes;
  logic [2:0]                shift;
  logic [THRESHOLD_BITS-1:0] threshold;
  logic                      busy;

  int n_checks = 0;
  int n_errors = 0;

  int                  mem_m [NEURONS];
  logic [SYNAPSES-1:0] w_m   [NEURONS];
  logic [NEURONS-1:0]  exp_q [$];
  logic [NEURONS-1:0]  last_exp;

  lif_layer_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_spikes       (in_spikes),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_spikes      (out_spikes),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .clear_membranes (clear_membranes),
    .shift           (shift),
    .threshold       (threshold),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NEURONS; n++) begin
      mem_m[n] = 0;
      w_m[n]   = '0;
    end
  endtask

  // Layer behaviour straight from the neuron equations, on plain integers.
  task automatic model_step(input logic [SYNAPSES-1:0] sp, input logic [2:0] sh,
                            input logic [THRESHOLD_BITS-1:0] th, input logic clr,
                            output logic [NEURONS-1:0] spikes);
    int psp, u, acc, thr;
    spikes = '0;
    thr = int'(th);
    if (clr) begin
      for (int n = 0; n < NEURONS; n++) mem_m[n] = 0;
    end
    for (int n = 0; n < NEURONS; n++) begin
      psp = 0;
      for (int i = 0; i < SYNAPSES; i++) begin
        if (sp[i]) psp += w_m[n][i] ? 1 : -1;
      end
      u = mem_m[n];
      if (sh != 0) u = u - (u >>> sh);
      acc = u + psp;
      if (acc > MEM_MAX) acc = MEM_MAX;
      if (acc < MEM_MIN) acc = MEM_MIN;
      if (acc >= thr) begin
        spikes[n] = 1'b1;
        mem_m[n]  = acc - thr;
      end else begin
        mem_m[n] = acc;
      end
    end
  endtask

  task automatic cfg(input logic [NIDX_BITS-1:0] a, input logic [SYNAPSES-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    w_m[a] = d;
  endtask

  task automatic send(input logic [SYNAPSES-1:0] sp, input logic [2:0] sh,
                      input logic [THRESHOLD_BITS-1:0] th, input logic clr);
    logic [NEURONS-1:0] e;
    bit ok;
    ok              = 1'b0;
    in_valid        = 1'b1;
    in_spikes       = sp;
    shift           = sh;
    threshold       = th;
    clear_membranes = clr;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid        = 1'b0;
    clear_membranes = 1'b0;
    model_step(sp, sh, th, clr, e);
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n = c;
        break;
      end
    end
    check("out_valid_latency", n, NEURONS + 1);
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: consumes one expected vector per accepted output.
  initial begin
    logic [NEURONS-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_spikes", out_spikes, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic stall;
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_spikes       = '0;
    out_ready       = 1'b1;
    cfg_we          = 1'b0;
    cfg_addr        = '0;
    cfg_data        = '0;
    clear_membranes = 1'b0;
    shift           = '0;
    threshold       = '0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_out_spikes", out_spikes, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First timestep on zero weights: every neuron sees -8 and stays silent.
    send(8'hFF, 3'd0, 4'd5, 1'b0);
    wait_out();

    cfg(2'd0, 8'hFF);
    cfg(2'd1, 8'h00);
    cfg(2'd2, SYNAPSES'($urandom));
    cfg(2'd3, SYNAPSES'($urandom));

    // Integrate from zero, n0 crosses threshold on step 2, n1 saturates negative.
    send(8'h0F, 3'd0, 4'd5, 1'b1);
    wait_out();
    repeat (4) begin
      send(8'h0F, 3'd0, 4'd5, 1'b0);
      wait_out();
    end

    // Backpressure in DONE with an ignored weight write.
    out_ready = 1'b0;
    send(SYNAPSES'($urandom), 3'd1, 4'd3, 1'b0);
    wait_out();
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = ~w_m[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_spikes", out_spikes, last_exp);
      check("stall_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    send(8'hFF, 3'd0, 4'd5, 1'b0);
    wait_out();

    // Clear and handshake together.
    send(8'h0F, 3'd0, 4'd5, 1'b1);
    wait_out();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) cfg(NIDX_BITS'($urandom), SYNAPSES'($urandom));
      stall     = ($urandom_range(0, 3) == 0);
      out_ready = !stall;
      send(SYNAPSES'($urandom), 3'($urandom_range(0, 7)),
           THRESHOLD_BITS'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      wait_out();
      if (stall) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset while the third neuron is in the datapath.
    send(SYNAPSES'($urandom), 3'd2, 4'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("run_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_out_valid", out_valid, 1'b0);
    check("midrun_reset_in_ready", in_ready, 1'b1);
    check("midrun_reset_busy", busy, 1'b0);
    check("midrun_reset_out_spikes", out_spikes, '0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hFF, 3'd0, 4'd5, 1'b0);
    wait_out();
    send(8'hF0, 3'd0, 4'd0, 1'b0);
    wait_out();

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexes one shared LIF datapath across NEURONS virtual neurons of a single layer.
- Holds per-neuron binary weight rows and membrane potentials in local registers.
- Per timestep, accepts an input spike vector through a valid/ready handshake and sequences every neuron through the datapath, one neuron per cycle.
- Returns the layer's output spike vector through a second valid/ready handshake. Sits between the input/config shift logic and the next layer (or the chip outputs).

Parameters:
- NEURONS, 4, number of virtual neurons sharing the datapath (power of two, ≥2)
- SYNAPSES, 8, inputs per neuron (power of two)
- STAGE, $clog2(SYNAPSES), adder-tree depth
- MEMBRANE_BITS, STAGE+2, signed membrane width
- THRESHOLD_BITS, MEMBRANE_BITS-1, unsigned threshold width
- NIDX_BITS, $clog2(NEURONS), neuron index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input spike vector valid
- in_ready  out  1  scheduler can accept a timestep
- in_spikes  in  SYNAPSES  input spike vector for this timestep
- out_valid  out  1  output spike vector valid
- out_ready  in  1  consumer accepts output
- out_spikes  out  NEURONS  one spike bit per neuron
- cfg_we  in  1  weight-row write strobe
- cfg_addr  in  NIDX_BITS  neuron index of weight row
- cfg_data  in  SYNAPSES  weight row (bit=1 → +1, bit=0 → −1)
- clear_membranes  in  1  zero all membranes
- shift  in  3  decay shift (0 = no decay)
- threshold  in  THRESHOLD_BITS  spike threshold
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, async): state IDLE, all membranes 0, all weight rows 0, out_spikes 0, out_valid 0, in_ready 1, busy 0, neuron index 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid&&in_ready: latch in_spikes, shift and threshold into timestep registers; clear the spike accumulator; index←0; next state RUN.
  - cfg_we writes weights[cfg_addr]←cfg_data.
  - clear_membranes zeroes all membranes. If clear_membranes and the in handshake occur in the same cycle, the clear applies first and the timestep starts from zero membranes.
- RUN: in_ready=0. Each cycle:
  - Datapath evaluates neuron[index] using membrane[index], weights[index] and the latched inputs/shift/threshold.
  - membrane[index]←new membrane; spike accumulator bit[index]←spike.
  - If index==NEURONS-1, next state DONE; otherwise index+1.
- DONE: out_valid=1, out_spikes=accumulator, held stable until out_ready. On out_valid&&out_ready, next state IDLE, out_valid←0 on that edge.
- Latency: the in handshake in cycle T gives out_valid high from cycle T+NEURONS+1. Throughput is one timestep per NEURONS+2 cycles with out_ready held high.
- cfg_we and clear_membranes are ignored outside IDLE (no error flag). Weights are never modified mid-timestep.
- Datapath arithmetic:
  - psp = Σ over set input bits of (w ? +1 : −1).
  - Decayed u = u − (u >>> shift) for shift>0; u unchanged for shift=0.
  - Accumulate with a saturating signed add clamped to [−2^(MEMBRANE_BITS−1), 2^(MEMBRANE_BITS−1)−1].
  - spike = acc ≥ threshold (threshold zero-extended, signed compare).
  - On spike, new membrane = acc − threshold (reset by subtraction); otherwise acc.
- Membranes persist across timesteps. Only reset and clear_membranes zero them.
- Async reset mid-RUN or mid-DONE: immediate return to IDLE. The partial timestep is discarded and membranes are zeroed.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DONE)
  - weight bit polarity constants
  - MEMBRANE_BITS/THRESHOLD_BITS derivation functions
- One sub-module: the existing lif_logic datapath, instantiated once and fed by index-selected muxes.
- Weight and membrane storage, the muxes and the FSM stay in lif_layer_scheduler.

Test Plan:
- Run after reset with no config writes: in_spikes=0xFF → out_valid at T+5, out_spikes=0000, all membranes −8.
- Config: weights[0]=0xFF, weights[1]=0x00, threshold=5, shift=0, out_ready=1.
  - Step 1, in_spikes=0x0F → n0 membrane 4, no spike.
  - Step 2 → n0 acc 8, spike, membrane 3; out_spikes bit0=1.
- Same config, n1 over five steps with in_spikes=0x0F → membrane −4, −8, −12, −16, −16 (saturates, no wrap), never spikes.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid and out_spikes stable, in_ready=0.
  - A cfg_we pulse during DONE leaves weights unchanged.
- clear_membranes and the in handshake in the same IDLE cycle, n0 membrane previously 3 → step computed from 0.
- Assert rst_n low during RUN at index 2 → out_valid=0 and in_ready=1 immediately; next timestep behaves as the first after reset.
